link_tlp_reassembler: RTL and testbench

- Receive side of the per-link 40-bit word stream produced by the input link router egress.
- Rebuilds the 96-bit TLP header from three header beats and queues the 32-bit payload dwords in a FIFO.
- Presents header and payload to the link-side consumer with valid/accept handshakes.
- One instance per link. It drives the buffer_ready flag the router gates its output on.

---
 rtl/link_pkg.sv | 24 ++
 rtl/link_sync_fifo.sv | 51 +++++
 rtl/link_tlp_reassembler.sv | 170 +++++++++++++++++
 tb/tb_link_tlp_reassembler.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared definitions for the link-side blocks: word field positions, header fields
// and the reassembler state encoding.
package link_pkg;

  localparam int SOP_BIT     = 39;
  localparam int LINK_LSB    = 32;
  localparam int DATA_MSB    = 31;
  localparam int HAS_PLD_BIT = 30;
  localparam int LEN_MSB     = 9;
  localparam int HDR_BEATS   = 3;

  typedef logic [2:0] state_t;
  localparam state_t ST_HDR0 = 3'd0;
  localparam state_t ST_HDR1 = 3'd1;
  localparam state_t ST_HDR2 = 3'd2;
  localparam state_t ST_PLD  = 3'd3;
  localparam state_t ST_HOLD = 3'd4;

  // A length field of zero encodes the maximum payload of 1024 dwords.
  function automatic logic [10:0] pld_count(input logic [LEN_MSB:0] len);
    return (len == '0) ? 11'd1024 : {1'b0, len};
  endfunction

endpackage

// File: rtl/link_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head entry is readable
// combinationally, and an empty FIFO presents zero on rd_data.
module link_sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_wr, do_rd;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/link_tlp_reassembler.sv
// Per-link receive side: rebuilds the 96-bit TLP header from three beats and
// queues payload dwords in a FWFT FIFO for the link-side consumer.
module link_tlp_reassembler
  import link_pkg::*;
#(
  parameter logic [1:0] LINK_ID   = 2'd0,
  parameter int         PLD_DEPTH = 16,
  parameter int         PLD_AW    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [39:0] header_word,
  input  logic        header_word_valid,
  input  logic [39:0] payload_word,
  input  logic        payload_word_valid,
  output logic        buffer_ready,
  output logic [95:0] header_out,
  output logic        header_valid,
  input  logic        header_accept,
  output logic [31:0] payload_out,
  output logic        payload_valid,
  input  logic        payload_accept,
  output logic        proto_error
);

  state_t      state_q, state_d;
  logic [31:0] dw0_q, dw0_d, dw1_q, dw1_d;
  logic [95:0] header_out_q, header_out_d;
  logic        header_valid_q, header_valid_d;
  logic [10:0] rem_q, rem_d;
  logic        err_q, err_d;
  logic        rdy_en_q, rdy_en_d;
  logic        fifo_full, fifo_empty, push;
  logic        hdr_acc, pld_acc, hdr_sop, hdr_id_ok, hdr_rsvd_ok, pld_rsvd_ok;
  logic [31:0] hdr_data;

  assign hdr_data    = header_word[DATA_MSB:0];
  assign hdr_sop     = header_word[SOP_BIT];
  assign hdr_id_ok   = (header_word[LINK_LSB+1:LINK_LSB] == LINK_ID);
  assign hdr_rsvd_ok = (header_word[SOP_BIT-1:LINK_LSB+2] == '0);
  assign pld_rsvd_ok = (payload_word[SOP_BIT:LINK_LSB] == '0);
  assign hdr_acc     = header_word_valid && buffer_ready;
  assign pld_acc     = payload_word_valid && buffer_ready;
  assign push        = (state_q == ST_PLD) && pld_acc && pld_rsvd_ok;

  // rdy_en_q keeps buffer_ready low until the first cycle after reset is released.
  always_comb begin
    buffer_ready = 1'b0;
    case (state_q)
      ST_HDR0: buffer_ready = !header_valid_q;
      ST_HDR1: buffer_ready = 1'b1;
      ST_HDR2: buffer_ready = 1'b1;
      ST_PLD:  buffer_ready = !fifo_full;
      default: buffer_ready = 1'b0;
    endcase
    buffer_ready = buffer_ready && rdy_en_q;
  end

  always_comb begin
    state_d        = state_q;
    dw0_d          = dw0_q;
    dw1_d          = dw1_q;
    header_out_d   = header_out_q;
    header_valid_d = header_valid_q;
    rem_d          = rem_q;
    rdy_en_d       = 1'b1;
    err_d          = (header_word_valid || payload_word_valid) && !buffer_ready;
    if (header_valid_q && header_accept) header_valid_d = 1'b0;
    case (state_q)
      ST_HDR0: begin
        if (pld_acc) err_d = 1'b1;
        if (hdr_acc) begin
          if (hdr_sop && hdr_id_ok && hdr_rsvd_ok) begin
            dw0_d   = hdr_data;
            state_d = ST_HDR1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_HDR1: begin
        if (pld_acc) err_d = 1'b1;
        if (hdr_acc) begin
          if (!hdr_rsvd_ok) begin
            err_d = 1'b1;
          end else if (!hdr_sop) begin
            dw1_d   = hdr_data;
            state_d = ST_HDR2;
          end else begin
            // An unexpected SOP starts a fresh header if it belongs to this link.
            err_d = 1'b1;
            if (hdr_id_ok) dw0_d = hdr_data;
            else           state_d = ST_HDR0;
          end
        end
      end
      ST_HDR2: begin
        if (pld_acc) err_d = 1'b1;
        if (hdr_acc) begin
          if (!hdr_rsvd_ok) begin
            err_d = 1'b1;
          end else begin
            header_out_d   = {hdr_data, dw1_q, dw0_q};
            header_valid_d = 1'b1;
            rem_d          = pld_count(dw0_q[LEN_MSB:0]);
            state_d        = dw0_q[HAS_PLD_BIT] ? ST_PLD : ST_HOLD;
          end
        end
      end
      ST_PLD: begin
        if (hdr_acc) err_d = 1'b1;
        if (pld_acc) begin
          if (!pld_rsvd_ok) begin
            err_d = 1'b1;
          end else begin
            rem_d = rem_q - 11'd1;
            if (rem_q == 11'd1) state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!header_valid_q) state_d = ST_HDR0;
      end
      default: state_d = ST_HDR0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_HDR0;
      dw0_q          <= '0;
      dw1_q          <= '0;
      header_out_q   <= '0;
      header_valid_q <= 1'b0;
      rem_q          <= '0;
      err_q          <= 1'b0;
      rdy_en_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      dw0_q          <= dw0_d;
      dw1_q          <= dw1_d;
      header_out_q   <= header_out_d;
      header_valid_q <= header_valid_d;
      rem_q          <= rem_d;
      err_q          <= err_d;
      rdy_en_q       <= rdy_en_d;
    end
  end

  link_sync_fifo #(
    .W     (32),
    .DEPTH (PLD_DEPTH),
    .AW    (PLD_AW)
  ) u_pld_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (payload_word[DATA_MSB:0]),
    .rd_en   (payload_accept),
    .rd_data (payload_out),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign payload_valid = !fifo_empty;
  assign header_out    = header_out_q;
  assign header_valid  = header_valid_q;
  assign proto_error   = err_q;

endmodule

// File: tb/tb_link_tlp_reassembler.sv
// Directed bench for link_tlp_reassembler at LINK_ID=2, PLD_DEPTH=16.
module tb_link_tlp_reassembler;

  logic        clk = 1'b0;
  logic        reset;
  logic [39:0] header_word;
  logic        header_word_valid;
  logic [39:0] payload_word;
  logic        payload_word_valid;
  logic        buffer_ready;
  logic [95:0] header_out;
  logic        header_valid;
  logic        header_accept;
  logic [31:0] payload_out;
  logic        payload_valid;
  logic        payload_accept;
  logic        proto_error;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  link_tlp_reassembler #(
    .LINK_ID   (2'd2),
    .PLD_DEPTH (16),
    .PLD_AW    (4)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .header_word        (header_word),
    .header_word_valid  (header_word_valid),
    .payload_word       (payload_word),
    .payload_word_valid (payload_word_valid),
    .buffer_ready       (buffer_ready),
    .header_out         (header_out),
    .header_valid       (header_valid),
    .header_accept      (header_accept),
    .payload_out        (payload_out),
    .payload_valid      (payload_valid),
    .payload_accept     (payload_accept),
    .proto_error        (proto_error)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [31:0] dw0, input logic [31:0] dw1, input logic [31:0] dw2);
    header_word_valid = 1'b1;
    header_word = {1'b1, 5'b0, 2'd2, dw0};
    tick();
    header_word = {8'h00, dw1};
    tick();
    header_word = {8'h00, dw2};
    tick();
    header_word_valid = 1'b0;
    $display("tlp header %08h_%08h_%08h sent", dw2, dw1, dw0);
    chk("hdr_valid", {95'd0, header_valid}, 96'd1);
    chk("hdr_out", header_out, {dw2, dw1, dw0});
  endtask

  task automatic accept_hdr();
    header_accept = 1'b1;
    tick();
    header_accept = 1'b0;
    chk("hdr_cleared", {95'd0, header_valid}, 96'd0);
    chk("hold_ready_low", {95'd0, buffer_ready}, 96'd0);
    tick();
    chk("back_to_hdr0", {95'd0, buffer_ready}, 96'd1);
  endtask

  // Pushes n dwords (base, base+1, ...) whenever buffer_ready is high and pops them
  // against a queue; with stall>0 the consumer holds off until stall dwords are queued.
  task automatic stream(input int n, input logic [31:0] base, input int stall);
    int sent;
    int cyc;
    bit released;
    logic [31:0] q[$];
    sent = 0;
    cyc = 0;
    released = (stall == 0);
    while ((sent < n || q.size() > 0) && cyc < 3000) begin
      if (!released && sent == stall) begin
        chk("bp_ready_low", {95'd0, buffer_ready}, 96'd0);
        released = 1'b1;
      end
      chk("pld_valid", {95'd0, payload_valid}, {95'd0, q.size() != 0});
      payload_accept = released;
      payload_word_valid = (sent < n) && buffer_ready;
      payload_word = {8'h00, base + sent};
      if (payload_accept && payload_valid && q.size() > 0) begin
        chk("pld_order", {64'd0, payload_out}, {64'd0, q[0]});
        void'(q.pop_front());
      end
      if (payload_word_valid) begin
        q.push_back(base + sent);
        sent++;
      end
      tick();
      chk("pld_no_err", {95'd0, proto_error}, 96'd0);
      cyc++;
    end
    payload_word_valid = 1'b0;
    payload_accept = 1'b0;
    chk("stream_done", {64'd0, sent}, {64'd0, n});
    $display("payload stream of %0d dwords from %08h done", sent, base);
  endtask

  initial begin
    reset = 1'b1;
    header_word = '0;
    header_word_valid = 1'b0;
    payload_word = '0;
    payload_word_valid = 1'b0;
    header_accept = 1'b0;
    payload_accept = 1'b0;
    tick(); tick(); tick();
    chk("rst_ready", {95'd0, buffer_ready}, 96'd0);
    chk("rst_hvalid", {95'd0, header_valid}, 96'd0);
    chk("rst_pvalid", {95'd0, payload_valid}, 96'd0);
    chk("rst_hout", header_out, 96'd0);
    chk("rst_pout", {64'd0, payload_out}, 96'd0);
    chk("rst_err", {95'd0, proto_error}, 96'd0);
    reset = 1'b0;
    tick();
    chk("ready_after_rst", {95'd0, buffer_ready}, 96'd1);

    // No-payload TLP
    send_hdr(32'h2000_0001, 32'h0000_0002, 32'h0000_0003);
    chk("nopld_hout", header_out, 96'h00000003_00000002_20000001);
    chk("nopld_ready_low", {95'd0, buffer_ready}, 96'd0);
    chk("nopld_no_pld", {95'd0, payload_valid}, 96'd0);
    tick();
    chk("hdr_holds", {95'd0, header_valid}, 96'd1);
    accept_hdr();

    // Three-dword payload
    send_hdr(32'h4000_0003, 32'h0000_0011, 32'h0000_0022);
    chk("pld_ready", {95'd0, buffer_ready}, 96'd1);
    stream(3, 32'h0000_000A, 0);
    chk("pld3_hold", {95'd0, buffer_ready}, 96'd0);
    accept_hdr();

    // Backpressure: 20 dwords into a 16-deep FIFO
    send_hdr(32'h4000_0014, 32'h0000_0033, 32'h0000_0044);
    stream(20, 32'h0000_0100, 16);
    chk("bp_hold", {95'd0, buffer_ready}, 96'd0);
    accept_hdr();

    // First beat without SOP
    header_word = {8'h00, 32'hDEAD_0000};
    header_word_valid = 1'b1;
    tick();
    header_word_valid = 1'b0;
    chk("nosop_err", {95'd0, proto_error}, 96'd1);
    chk("nosop_ready", {95'd0, buffer_ready}, 96'd1);
    tick();
    chk("nosop_pulse", {95'd0, proto_error}, 96'd0);
    // SOP beat for link 1
    header_word = {8'h81, 32'hBEEF_0000};
    header_word_valid = 1'b1;
    tick();
    header_word_valid = 1'b0;
    chk("badid_err", {95'd0, proto_error}, 96'd1);
    tick();
    chk("badid_pulse", {95'd0, proto_error}, 96'd0);
    send_hdr(32'h2000_0005, 32'h0000_0006, 32'h0000_0007);
    accept_hdr();

    // Length 0 means 1024 dwords
    send_hdr(32'h4000_0000, 32'h0000_0008, 32'h0000_0009);
    stream(1024, 32'h0000_1000, 0);
    chk("len0_hold", {95'd0, buffer_ready}, 96'd0);
    payload_word = {8'h00, 32'h0000_FFFF};
    payload_word_valid = 1'b1;
    tick();
    payload_word_valid = 1'b0;
    chk("extra_pld_err", {95'd0, proto_error}, 96'd1);
    chk("extra_pld_dropped", {95'd0, payload_valid}, 96'd0);
    accept_hdr();

    // Reset in the middle of a header
    header_word_valid = 1'b1;
    header_word = {8'h82, 32'h4000_0002};
    tick();
    header_word = {8'h00, 32'h0000_0077};
    tick();
    header_word_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("mid_rst_ready", {95'd0, buffer_ready}, 96'd0);
    chk("mid_rst_hout", header_out, 96'd0);
    chk("mid_rst_hvalid", {95'd0, header_valid}, 96'd0);
    chk("mid_rst_pvalid", {95'd0, payload_valid}, 96'd0);
    reset = 1'b0;
    tick();
    chk("mid_rst_ready_up", {95'd0, buffer_ready}, 96'd1);
    send_hdr(32'h4000_0002, 32'h0000_0055, 32'h0000_0066);
    stream(2, 32'h0000_0200, 0);
    accept_hdr();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
